// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and defaults for the two-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} gnt_e;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEADBEEF;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_req_t;
endpackage

// File: rtl/wb_timeout_watchdog.sv
// wb_timeout_watchdog: fakes an ack when a granted strobe waits too long and counts the events
module wb_timeout_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wait_i,
  input  logic       ack_i,
  output logic       timeout_o,
  output logic [7:0] timeout_count_o
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d, evt_q, evt_d;
  always_comb begin
    timeout_o = wait_i && !ack_i && cnt_q == LIMIT;
    cnt_d     = (!wait_i || ack_i || timeout_o) ? 8'd0 : cnt_q + 8'd1;
    evt_d     = (timeout_o && evt_q != 8'hFF) ? evt_q + 8'd1 : evt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end
  assign timeout_count_o = evt_q;
endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin two-master Wishbone arbiter with bus-timeout watchdog
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_DATA   = DEF_TIMEOUT_DATA
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        timeout_o,
  output logic [7:0]  timeout_count_o
);
  gnt_e        gnt_q;
  logic        last_m1_q;
  wb_req_t     m0_req, m1_req, g_req;
  logic        to;
  logic [31:0] resp_dat;
  assign m0_req = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_stb_i, m0_cyc_i};
  assign m1_req = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i};
  assign g_req  = gnt_q == GNT_M0 ? m0_req : gnt_q == GNT_M1 ? m1_req : '0;
  // ties go to whichever master was not served last; the grant holds until cyc drops
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gnt_q     <= GNT_NONE;
      last_m1_q <= 1'b1;
    end else if (gnt_q == GNT_NONE) begin
      gnt_q <= (m0_cyc_i && m1_cyc_i) ? (last_m1_q ? GNT_M0 : GNT_M1) :
               m0_cyc_i ? GNT_M0 : m1_cyc_i ? GNT_M1 : GNT_NONE;
    end else if (!g_req.cyc) begin
      gnt_q     <= GNT_NONE;
      last_m1_q <= gnt_q == GNT_M1;
    end
  end
  wb_timeout_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk             (sys_clk),
    .rst             (sys_rst),
    .wait_i          (g_req.stb & g_req.cyc),
    .ack_i           (s_ack_i),
    .timeout_o       (to),
    .timeout_count_o (timeout_count_o)
  );
  assign timeout_o = to;
  assign s_adr_o   = g_req.adr;
  assign s_dat_o   = g_req.dat;
  assign s_sel_o   = g_req.sel;
  assign s_we_o    = g_req.we;
  assign s_stb_o   = g_req.stb & ~to;
  assign s_cyc_o   = g_req.cyc & ~to;
  assign resp_dat  = to ? TIMEOUT_DATA : s_dat_i;
  assign m0_ack_o  = gnt_q == GNT_M0 && (s_ack_i || to);
  assign m1_ack_o  = gnt_q == GNT_M1 && (s_ack_i || to);
  assign m0_dat_o  = gnt_q == GNT_M0 ? resp_dat : '0;
  assign m1_dat_o  = gnt_q == GNT_M1 ? resp_dat : '0;
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_wb_master_arbiter;
  localparam int          T  = 4;
  localparam logic [31:0] TD = 32'hDEADBEEF;
  logic        sys_clk = 0, sys_rst = 1;
  logic [31:0] m0_adr = 0, m0_dat = 0, m1_adr = 0, m1_dat = 0, s_dat = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic        m0_stb = 0, m0_cyc = 0, m0_we = 0, m1_stb = 0, m1_cyc = 0, m1_we = 0, s_ack = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m1_ack_o, s_stb_o, s_cyc_o, s_we_o, timeout_o;
  logic [7:0]  timeout_count_o;
  int n_cmp = 0, n_bad = 0;
  always #5 sys_clk = ~sys_clk;
  wb_master_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_stb_i(m0_stb),
    .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_stb_i(m1_stb),
    .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
  );
  // behavioural model: owner -1/0/1, cycles the granted strobe has waited, timeout tally
  int own = -1, last = 1, wt = 0, tcnt = 0;
  function automatic logic [70:0] req_of(int o);
    return o == 0 ? {m0_adr, m0_dat, m0_sel, m0_we, m0_stb, m0_cyc} :
           o == 1 ? {m1_adr, m1_dat, m1_sel, m1_we, m1_stb, m1_cyc} : 71'd0;
  endfunction
  function automatic bit active();
    logic [70:0] r;
    r = req_of(own);
    return r[1] && r[0];
  endfunction
  function automatic bit model_to();
    return active() && !s_ack && wt == T;
  endfunction
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      own <= -1; last <= 1; wt <= 0; tcnt <= 0;
    end else begin
      wt <= (active() && !s_ack && !model_to()) ? wt + 1 : 0;
      if (model_to()) tcnt <= tcnt < 255 ? tcnt + 1 : 255;
      if (own < 0) own <= (m0_cyc && m1_cyc) ? (last == 1 ? 0 : 1) : m0_cyc ? 0 : m1_cyc ? 1 : -1;
      else if (!(own == 0 ? m0_cyc : m1_cyc)) begin own <= -1; last <= own; end
    end
  end
  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic idle();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
  endtask
  task automatic test_reset();
    sys_rst = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h44;
    nxt(); nxt();
    @(negedge sys_clk);
    n_cmp++; if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o} !== 71'd0) begin n_bad++; $display("FAIL reset_slave: got %h want 0", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o}); end
    n_cmp++; if ({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, timeout_o} !== 67'd0) begin n_bad++; $display("FAIL reset_master: got %h want 0", {m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, timeout_o}); end
    n_cmp++; if (timeout_count_o !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", timeout_count_o); end
    idle(); sys_rst = 0;
    nxt();
  endtask
  task automatic test_m1_read();
    int acks = 0;
    m1_adr = 32'h10; m1_we = 0; m1_sel = 4'hF; m1_cyc = 1; m1_stb = 1;
    @(negedge sys_clk);
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL m1_pregrant_cyc: got %b want 0", s_cyc_o); end
    for (int k = 1; k <= 3; k++) begin
      nxt();
      s_ack = k == 3;
      s_dat = k == 3 ? 32'h12345678 : 32'h0BAD0BAD;
      @(negedge sys_clk);
      n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL m1_granted_cyc k=%0d: got %b want 1", k, s_cyc_o); end
      n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL m1_read_m0ack k=%0d: got %b want 0", k, m0_ack_o); end
      if (k == 1) begin
        n_cmp++; if (s_adr_o !== 32'h10) begin n_bad++; $display("FAIL m1_adr: got %h want 10", s_adr_o); end
      end
      if (k == 3) begin
        n_cmp++; if (m1_dat_o !== 32'h12345678) begin n_bad++; $display("FAIL m1_rdata: got %h want 12345678", m1_dat_o); end
      end
      acks += int'(m1_ack_o);
    end
    nxt();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge sys_clk);
    acks += int'(m1_ack_o);
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL m1_ack_count: got %0d want 1", acks); end
    nxt();
  endtask
  task automatic test_round_robin();
    sys_rst = 1; nxt(); sys_rst = 0;
    m0_adr = 32'hA000_0000; m1_adr = 32'hB000_0000; m0_stb = 0; m1_stb = 0;
    m0_cyc = 1; m1_cyc = 1;
    nxt();
    @(negedge sys_clk);
    n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'hA000_0000}) begin n_bad++; $display("FAIL rr_first_m0: got %h want 1a0000000", {s_cyc_o, s_adr_o}); end
    m0_cyc = 0;
    nxt();
    @(negedge sys_clk);
    n_cmp++; if ({s_cyc_o, s_adr_o} !== 33'd0) begin n_bad++; $display("FAIL rr_dead_cycle: got %h want 0", {s_cyc_o, s_adr_o}); end
    nxt();
    @(negedge sys_clk);
    n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'hB000_0000}) begin n_bad++; $display("FAIL rr_then_m1: got %h want 1b0000000", {s_cyc_o, s_adr_o}); end
    m1_cyc = 0; m0_cyc = 1;
    nxt();
    m1_cyc = 1;
    @(negedge sys_clk);
    n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rr_dead_cycle2: got %b want 0", s_cyc_o); end
    nxt();
    @(negedge sys_clk);
    n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'hA000_0000}) begin n_bad++; $display("FAIL rr_back_to_m0: got %h want 1a0000000", {s_cyc_o, s_adr_o}); end
    idle(); nxt(); nxt();
  endtask
  task automatic test_timeout();
    sys_rst = 1; nxt(); sys_rst = 0;
    m1_adr = 32'hF000_0000; m1_we = 1; m1_dat = 32'h5555AAAA; m1_cyc = 1; m1_stb = 1;
    nxt();
    for (int k = 0; k <= T; k++) begin
      @(negedge sys_clk);
      if (k < T) begin
        n_cmp++; if ({m1_ack_o, timeout_o, s_stb_o, s_we_o} !== 4'b0011) begin n_bad++; $display("FAIL to_wait k=%0d: got %b want 0011", k, {m1_ack_o, timeout_o, s_stb_o, s_we_o}); end
      end else begin
        n_cmp++; if ({m1_ack_o, timeout_o, s_stb_o, s_cyc_o} !== 4'b1100) begin n_bad++; $display("FAIL to_fire: got %b want 1100", {m1_ack_o, timeout_o, s_stb_o, s_cyc_o}); end
        n_cmp++; if (m1_dat_o !== TD) begin n_bad++; $display("FAIL to_data: got %h want %h", m1_dat_o, TD); end
      end
      nxt();
    end
    @(negedge sys_clk);
    n_cmp++; if ({m1_ack_o, timeout_count_o} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL to_after: got %h want 001", {m1_ack_o, timeout_count_o}); end
    idle(); nxt(); nxt();
  endtask
  task automatic test_ack_at_limit();
    m0_adr = 32'h20; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    nxt();
    for (int k = 0; k <= T; k++) begin
      s_ack = k == T;
      s_dat = 32'hA5A50001;
      @(negedge sys_clk);
      if (k < T) begin
        n_cmp++; if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL limit_wait k=%0d: got %b want 0", k, m0_ack_o); end
      end else begin
        n_cmp++; if ({m0_ack_o, timeout_o, m0_dat_o} !== {2'b10, 32'hA5A50001}) begin n_bad++; $display("FAIL limit_real_ack: got %h want 2a5a50001", {m0_ack_o, timeout_o, m0_dat_o}); end
      end
      nxt();
    end
    idle();
    @(negedge sys_clk);
    n_cmp++; if (timeout_count_o !== 8'd1) begin n_bad++; $display("FAIL limit_count: got %0d want 1", timeout_count_o); end
    nxt();
  endtask
  task automatic test_saturation();
    int pulses = 0;
    m1_cyc = 1; m1_stb = 1;
    nxt();
    repeat (300 * (T + 1)) begin
      @(negedge sys_clk);
      pulses += int'(timeout_o);
      nxt();
    end
    n_cmp++; if (pulses !== 300) begin n_bad++; $display("FAIL sat_pulses: got %0d want 300", pulses); end
    @(negedge sys_clk);
    n_cmp++; if (timeout_count_o !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d want 255", timeout_count_o); end
    idle(); nxt(); nxt();
  endtask
  task automatic test_reset_mid();
    m0_adr = 32'h30; m0_cyc = 1; m0_stb = 1;
    nxt(); nxt(); nxt();
    @(negedge sys_clk);
    n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_granted: got %b want 1", s_cyc_o); end
    sys_rst = 1;
    nxt();
    sys_rst = 0;
    @(negedge sys_clk);
    n_cmp++; if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o} !== 71'd0) begin n_bad++; $display("FAIL rstmid_slave: got %h want 0", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o}); end
    n_cmp++; if ({m0_ack_o, m1_ack_o, timeout_o, timeout_count_o} !== 11'd0) begin n_bad++; $display("FAIL rstmid_ack: got %h want 0", {m0_ack_o, m1_ack_o, timeout_o, timeout_count_o}); end
    nxt();
    for (int k = 0; k <= T; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        n_cmp++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h30}) begin n_bad++; $display("FAIL rstmid_regrant: got %h want 100000030", {s_cyc_o, s_adr_o}); end
      end
      n_cmp++; if (m0_ack_o !== (k == T)) begin n_bad++; $display("FAIL rstmid_timeout k=%0d: got %b want %b", k, m0_ack_o, k == T); end
      nxt();
    end
    idle(); nxt(); nxt();
  endtask
  task automatic test_random();
    logic [70:0] r;
    logic [74:0] exp_m, got_m;
    logic [70:0] exp_s, got_s;
    logic        t;
    logic [31:0] resp;
    sys_rst = 1; nxt(); sys_rst = 0;
    repeat (600) begin
      m0_cyc = m0_cyc ? $urandom_range(7) != 0 : $urandom_range(2) == 0;
      m1_cyc = m1_cyc ? $urandom_range(7) != 0 : $urandom_range(2) == 0;
      m0_stb = m0_cyc && $urandom_range(9) < 7;
      m1_stb = m1_cyc && $urandom_range(9) < 7;
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
      s_ack = $urandom_range(3) == 0; s_dat = $urandom;
      @(negedge sys_clk);
      r = req_of(own);
      t = model_to();
      resp = t ? TD : s_dat;
      exp_s = {r[70:2], r[1] & ~t, r[0] & ~t};
      exp_m = {own == 0 && (s_ack || t), own == 0 ? resp : 32'd0,
               own == 1 && (s_ack || t), own == 1 ? resp : 32'd0, t, 8'(tcnt)};
      got_s = {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o};
      got_m = {m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, timeout_o, timeout_count_o};
      n_cmp++; if (got_s !== exp_s) begin n_bad++; $display("FAIL rand_slave: got %h want %h", got_s, exp_s); end
      n_cmp++; if (got_m !== exp_m) begin n_bad++; $display("FAIL rand_master: got %h want %h", got_m, exp_m); end
      nxt();
    end
    idle(); nxt();
  endtask
  initial begin
    test_reset();
    test_m1_read();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
